// File: rtl/dac_frame_scheduler.sv
// -----------------------------------------------------------------------------
// dac_frame_scheduler
//
// Purpose:
//   Shares one SPI DAC link between waveform channels A and B. Each
//   sampling strobe starts one frame. A frame snapshots both channel words
//   and enables, then issues one 16-bit SPI write per participating channel,
//   A first and then B. Finally it pulses ldac_n low so that both DAC
//   outputs update on the same edge. A strobe that arrives while a frame is
//   still in progress sets the sticky overrun flag and is otherwise ignored.
//
// Word format sent to the SPI master:
//   [15] channel (0 = A, 1 = B)
//   [14] BUF_BIT   (VREF buffer control)
//   [13] GA_N_BIT  (gain select, 1 = 1x)
//   [12] SHDN_N    (1 = output active)
//   [11:0] DAC code
//
// Build option:
//   SAW_DAC_SHDN_EN - when defined, a disabled channel is not skipped.
//   It still receives a write, with SHDN_N = 0 and data 0, so that its
//   output is powered down. Every accepted strobe then produces a
//   two-write frame. When undefined, disabled channels are skipped, and a
//   strobe with both channels disabled starts no frame at all.
//
// Parameters:
//   BUF_BIT      value placed in word bit 14
//   GA_N_BIT     value placed in word bit 13
//   LDAC_CYCLES  clk cycles ldac_n is held low (1..15)
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   clk_sampling   one-cycle sampling strobe (50 kHz)
//   enableA/B      channel participates in frames
//   dacA/B_word    12-bit channel codes
//   spi_tx_data    word presented to the SPI master
//   spi_tx_start   one-cycle start request to the SPI master
//   spi_busy       SPI master transfer in progress
//   spi_done       one-cycle end-of-transfer pulse from the SPI master
//   ldac_n         DAC latch strobe, active-low
//   frame_active   high from strobe acceptance until the LDAC phase ends
//   overrun        sticky: strobe seen while a frame was active
//   overrun_clr    clears overrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module dac_frame_scheduler #(
  parameter logic        BUF_BIT     = 1'b1,
  parameter logic        GA_N_BIT    = 1'b1,
  parameter int unsigned LDAC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_sampling,
  input  logic        enableA,
  input  logic        enableB,
  input  logic [11:0] dacA_word,
  input  logic [11:0] dacB_word,
  output logic [15:0] spi_tx_data,
  output logic        spi_tx_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        ldac_n,
  output logic        frame_active,
  output logic        overrun,
  input  logic        overrun_clr
);

  // A disabled channel either keeps its slot (it is sent as a power-down
  // word) or it is dropped from the frame.
`ifdef SAW_DAC_SHDN_EN
  localparam logic KEEP_DISABLED_SLOTS = 1'b1;
`else
  localparam logic KEEP_DISABLED_SLOTS = 1'b0;
`endif

  // The LDAC counter runs from 0 up to LDAC_CYCLES-1. This gives exactly
  // LDAC_CYCLES cycles with ldac_n low.
  localparam logic [3:0] LDAC_LAST = 4'(LDAC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_A = 3'd1,
    S_WAIT_A  = 3'd2,
    S_START_B = 3'd3,
    S_WAIT_B  = 3'd4,
    S_LDAC    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        en_a_q, en_a_d;
  logic        en_b_q, en_b_d;
  logic [11:0] word_a_q, word_a_d;
  logic [11:0] word_b_q, word_b_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [3:0]  ldac_cnt_q, ldac_cnt_d;
  logic        overrun_q, overrun_d;

  logic        start_c;
  logic [15:0] tx_word_c;
  logic [15:0] frame_word_a;
  logic [15:0] frame_word_b;

  // Words are built from the snapshot only, so input changes that occur
  // mid-frame never reach the link. A disabled channel can only be sent
  // when disabled slots are kept. It then gets SHDN_N = 0 and zero data.
  assign frame_word_a = {1'b0, BUF_BIT, GA_N_BIT, en_a_q,
                         en_a_q ? word_a_q : 12'h000};
  assign frame_word_b = {1'b1, BUF_BIT, GA_N_BIT, en_b_q,
                         en_b_q ? word_b_q : 12'h000};

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    en_a_d     = en_a_q;
    en_b_d     = en_b_q;
    word_a_d   = word_a_q;
    word_b_d   = word_b_q;
    tx_data_d  = tx_data_q;
    ldac_cnt_d = ldac_cnt_q;
    start_c    = 1'b0;
    tx_word_c  = tx_data_q;

    // The set term is applied after the clear term, so a set and a clear
    // in the same cycle leave overrun set.
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (clk_sampling && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (clk_sampling) begin
          en_a_d   = enableA;
          en_b_d   = enableB;
          word_a_d = dacA_word;
          word_b_d = dacB_word;
          if (KEEP_DISABLED_SLOTS || enableA) begin
            state_d = S_START_A;
          end else if (enableB) begin
            state_d = S_START_B;
          end
        end
      end

      // The start request is combinational on !spi_busy. The first word
      // therefore goes out in the cycle right after the strobe edge. The
      // word is also driven combinationally in that cycle, and is registered
      // so that it stays stable for the rest of the transfer.
      S_START_A: begin
        if (!spi_busy) begin
          start_c   = 1'b1;
          tx_word_c = frame_word_a;
          tx_data_d = frame_word_a;
          state_d   = S_WAIT_A;
        end
      end

      S_WAIT_A: begin
        if (spi_done) begin
          ldac_cnt_d = 4'd0;
          if (KEEP_DISABLED_SLOTS || en_b_q) begin
            state_d = S_START_B;
          end else begin
            state_d = S_LDAC;
          end
        end
      end

      S_START_B: begin
        if (!spi_busy) begin
          start_c   = 1'b1;
          tx_word_c = frame_word_b;
          tx_data_d = frame_word_b;
          state_d   = S_WAIT_B;
        end
      end

      // There is deliberately no timeout. A lost spi_done parks the frame
      // here, and every later strobe is reported through overrun.
      S_WAIT_B: begin
        if (spi_done) begin
          ldac_cnt_d = 4'd0;
          state_d    = S_LDAC;
        end
      end

      S_LDAC: begin
        if (ldac_cnt_q == LDAC_LAST) begin
          state_d = S_IDLE;
        end else begin
          ldac_cnt_d = ldac_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      word_a_q   <= 12'h000;
      word_b_q   <= 12'h000;
      tx_data_q  <= 16'h0000;
      ldac_cnt_q <= 4'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      word_a_q   <= word_a_d;
      word_b_q   <= word_b_d;
      tx_data_q  <= tx_data_d;
      ldac_cnt_q <= ldac_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi_tx_data  = tx_word_c;
  assign spi_tx_start = start_c;
  assign ldac_n       = (state_q != S_LDAC);
  assign frame_active = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for dac_frame_scheduler.
// Contains an SPI master responder with configurable latency and a busy tail.
// Expected frames are built from the word rules of the scheduler: per
// enabled channel (or every channel when disabled slots are kept), A before
// B, then a single LDAC pulse.
// -----------------------------------------------------------------------------
module tb_dac_frame_scheduler;

  localparam int LDAC_CYCLES = 2;
`ifdef SAW_DAC_SHDN_EN
  localparam bit SHDN = 1'b1;
`else
  localparam bit SHDN = 1'b0;
`endif

  typedef logic [15:0] wq_t[$];

  typedef struct {
    bit          ea;
    bit          eb;
    logic [11:0] wa;
    logic [11:0] wb;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        clk_sampling;
  logic        enableA;
  logic        enableB;
  logic [11:0] dacA_word;
  logic [11:0] dacB_word;
  logic [15:0] spi_tx_data;
  logic        spi_tx_start;
  logic        spi_busy;
  logic        spi_done;
  logic        ldac_n;
  logic        frame_active;
  logic        overrun;
  logic        overrun_clr;

  dac_frame_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .clk_sampling (clk_sampling),
    .enableA      (enableA),
    .enableB      (enableB),
    .dacA_word    (dacA_word),
    .dacB_word    (dacB_word),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_start (spi_tx_start),
    .spi_busy     (spi_busy),
    .spi_done     (spi_done),
    .ldac_n       (ldac_n),
    .frame_active (frame_active),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counters and monitor state
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_start = 0;

  // Responder state
  bit resp_auto = 1'b1;
  int resp_lat = 3;
  int resp_tail = 0;
  int busy_cnt = 0;
  int tail_cnt = 0;
  int busy_hold = 0;
  int busy_fall_cyc = -1;
  bit pending_start = 1'b0;

  // Per-frame observations
  wq_t got;
  int  ldac_w[$];
  int  ldac_run = 0;
  int  first_start_cyc = -1;
  int  last_start_cyc = -1;
  int  strobe_cyc = 0;
  int  hold_err = 0;
  int  width_err = 0;
  int  start_busy_err = 0;
  bit  prev_start = 1'b0;
  logic [15:0] last_word = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input bit ch, input bit en, input logic [11:0] w);
    return {ch, 1'b1, 1'b1, en, (en ? w : 12'h000)};
  endfunction

  function automatic wq_t ref_frame(input bit ea, input bit eb, input logic [11:0] wa, input logic [11:0] wb);
    wq_t q;
    q = {};
    if (ea || SHDN) q.push_back(ref_word(1'b0, ea, wa));
    if (eb || SHDN) q.push_back(ref_word(1'b1, eb, wb));
    return q;
  endfunction

  // Runs one clock cycle. The responder drives the SPI inputs 1 time unit
  // after the rising edge. Outputs are observed on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (spi_done) spi_done = 1'b0;
    if (resp_auto) begin
      if (pending_start) begin
        pending_start = 1'b0;
        busy_cnt = resp_lat;
        tail_cnt = 0;
        spi_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          spi_done = 1'b1;
          tail_cnt = resp_tail;
          if (resp_tail == 0) spi_busy = 1'b0;
        end
      end else if (tail_cnt > 0) begin
        tail_cnt--;
        if (tail_cnt == 0) spi_busy = 1'b0;
      end else if (busy_hold > 0) begin
        busy_hold--;
        if (busy_hold == 0) begin
          spi_busy = 1'b0;
          busy_fall_cyc = cyc + 1;
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (spi_tx_start) begin
      n_start++;
      if (spi_busy) start_busy_err++;
      if (prev_start) width_err++;
      got.push_back(spi_tx_data);
      if (first_start_cyc < 0) first_start_cyc = cyc;
      last_start_cyc = cyc;
      last_word = spi_tx_data;
      pending_start = 1'b1;
    end else if (frame_active && got.size() > 0 && spi_tx_data !== last_word) begin
      hold_err++;
    end
    if (!ldac_n) begin
      ldac_run++;
    end else if (ldac_run > 0) begin
      ldac_w.push_back(ldac_run);
      ldac_run = 0;
    end
    prev_start = spi_tx_start;
  endtask

  task automatic run_frame(input string tag, input bit ea, input bit eb,
                           input logic [11:0] wa, input logic [11:0] wb, input wq_t exp,
                           input int lat, input int tail, input int hold,
                           input int inj_n, input bit inj_clr);
    int n;
    int fa;
    bit injected;
    bit busy_at_strobe;
    got = {};
    ldac_w = {};
    ldac_run = 0;
    first_start_cyc = -1;
    last_start_cyc = -1;
    hold_err = 0;
    width_err = 0;
    start_busy_err = 0;
    resp_lat = lat;
    resp_tail = tail;
    enableA = ea;
    enableB = eb;
    dacA_word = wa;
    dacB_word = wb;
    if (hold > 0) begin
      spi_busy = 1'b1;
      busy_hold = hold;
    end
    busy_at_strobe = spi_busy;
    clk_sampling = 1'b1;
    strobe_cyc = cyc;
    step();
    clk_sampling = 1'b0;

    if (exp.size() == 0) begin
      fa = frame_active ? 1 : 0;
      repeat (8) begin
        step();
        if (frame_active) fa++;
      end
      chk({tag, "_nstart"}, got.size(), 0);
      chk({tag, "_ldac"}, ldac_w.size() + ((ldac_run > 0) ? 1 : 0), 0);
      chk({tag, "_fa"}, fa, 0);
      chk({tag, "_ovr"}, overrun, 0);
      $display("frame %s: no frame, %0d starts", tag, got.size());
      return;
    end

    chk({tag, "_fa_rise"}, frame_active, 1);
    n = 0;
    injected = 1'b0;
    while (frame_active && n < 3000) begin
      if (!injected && inj_n > 0 && got.size() == inj_n && cyc > last_start_cyc) begin
        injected = 1'b1;
        clk_sampling = 1'b1;
        overrun_clr = inj_clr;
        enableA = ~ea;
        enableB = ~eb;
        dacA_word = ~wa;
        dacB_word = ~wb;
        step();
        clk_sampling = 1'b0;
        overrun_clr = 1'b0;
        chk({tag, "_ovr_set"}, overrun, 1);
      end else begin
        step();
      end
      n++;
    end

    chk({tag, "_frame_end"}, frame_active, 0);
    chk({tag, "_nwords"}, got.size(), exp.size());
    if (got.size() == exp.size()) begin
      foreach (exp[i]) chk({tag, $sformatf("_w%0d", i)}, got[i], exp[i]);
    end
    if (hold > 0) chk({tag, "_bp_start"}, first_start_cyc, busy_fall_cyc);
    else if (!busy_at_strobe) chk({tag, "_latency"}, first_start_cyc, strobe_cyc + 1);
    chk({tag, "_proto"}, hold_err + width_err + start_busy_err, 0);
    chk({tag, "_ldac_n_idle"}, ldac_n, 1);
    chk({tag, "_ldac_pulses"}, ldac_w.size(), 1);
    if (ldac_w.size() == 1) chk({tag, "_ldac_len"}, ldac_w[0], LDAC_CYCLES);
    if (injected) begin
      chk({tag, "_ovr_sticky"}, overrun, 1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk({tag, "_ovr_clr"}, overrun, 0);
    end else begin
      chk({tag, "_ovr_none"}, overrun, 0);
    end
    $display("frame %s: %0d words, first %h, ldac pulses %0d, overrun injected %0d",
             tag, got.size(), (got.size() > 0) ? got[0] : 16'h0, ldac_w.size(), injected);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    wq_t  exp;
    bit   ea;
    bit   eb;
    logic [11:0] wa;
    logic [11:0] wb;
    int   inj;
    int   hold;
    int   nst;
    int   fa;
    int   lo;
    int   k;

    vecs[0] = '{1'b1, 1'b1, 12'h800, 12'h123, 2, 16'h7800, 16'hF123};
`ifdef SAW_DAC_SHDN_EN
    vecs[1] = '{1'b0, 1'b1, 12'h456, 12'hFFF, 2, 16'h6000, 16'hFFFF};
    vecs[2] = '{1'b1, 1'b0, 12'hABC, 12'h555, 2, 16'h7ABC, 16'hE000};
    vecs[4] = '{1'b0, 1'b0, 12'h111, 12'h222, 2, 16'h6000, 16'hE000};
`else
    vecs[1] = '{1'b0, 1'b1, 12'h456, 12'hFFF, 1, 16'hFFFF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 12'hABC, 12'h555, 1, 16'h7ABC, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 12'h111, 12'h222, 0, 16'h0000, 16'h0000};
`endif
    vecs[3] = '{1'b1, 1'b1, 12'h000, 12'hFFF, 2, 16'h7000, 16'hFFFF};

    rst = 1'b1;
    clk_sampling = 1'b0;
    enableA = 1'b0;
    enableB = 1'b0;
    dacA_word = 12'h0;
    dacB_word = 12'h0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    overrun_clr = 1'b0;
    step();
    step();
    chk("rst_tx_data", spi_tx_data, 16'h0);
    chk("rst_tx_start", spi_tx_start, 0);
    chk("rst_ldac_n", ldac_n, 1);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    step();

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      exp = {};
      if (vecs[i].nw > 0) exp.push_back(vecs[i].w0);
      if (vecs[i].nw > 1) exp.push_back(vecs[i].w1);
      run_frame($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].wa, vecs[i].wb,
                exp, 3, 0, 0, 0, 1'b0);
      step();
    end

    // Busy back-pressure: spi_busy is held for 10 cycles after the strobe.
    exp = {16'h75A5, 16'hF0F0};
    run_frame("busy_bp", 1'b1, 1'b1, 12'h5A5, 12'h0F0, exp, 2, 0, 10, 0, 1'b0);
    step();

    // B still busy when START_B is entered. The busy tail keeps the
    // second start back.
    exp = {16'h7321, 16'hF654};
    run_frame("busy_tail", 1'b1, 1'b1, 12'h321, 12'h654, exp, 2, 2, 0, 0, 1'b0);
    step();

    // Overrun while in WAIT_B, followed by a clear pulse. Then a strobe in
    // WAIT_A arriving together with overrun_clr, where the set wins.
    exp = {16'h7800, 16'hF123};
    run_frame("ovr_waitb", 1'b1, 1'b1, 12'h800, 12'h123, exp, 4, 0, 0, 2, 1'b0);
    step();
    run_frame("ovr_setwins", 1'b1, 1'b1, 12'h800, 12'h123, exp, 4, 0, 0, 1, 1'b1);
    step();

    // Reset in WAIT_A, then a stale spi_done 3 cycles later.
    got = {};
    first_start_cyc = -1;
    last_start_cyc = -1;
    resp_lat = 1000;
    resp_tail = 0;
    enableA = 1'b1;
    enableB = 1'b1;
    dacA_word = 12'h3C3;
    dacB_word = 12'hC3C;
    clk_sampling = 1'b1;
    step();
    clk_sampling = 1'b0;
    k = 0;
    while (got.size() == 0 && k < 50) begin
      step();
      k++;
    end
    chk("rstmid_first_start", got.size(), 1);
    step();
    clk_sampling = 1'b1;
    step();
    clk_sampling = 1'b0;
    chk("rstmid_pre_overrun", overrun, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_tx_data", spi_tx_data, 16'h0);
    chk("rstmid_tx_start", spi_tx_start, 0);
    chk("rstmid_ldac_n", ldac_n, 1);
    chk("rstmid_frame_active", frame_active, 0);
    chk("rstmid_overrun", overrun, 0);
    resp_auto = 1'b0;
    pending_start = 1'b0;
    busy_cnt = 0;
    tail_cnt = 0;
    spi_busy = 1'b0;
    nst = n_start;
    repeat (3) step();
    spi_done = 1'b1;
    fa = 0;
    lo = 0;
    repeat (20) begin
      step();
      if (frame_active) fa++;
      if (!ldac_n) lo++;
    end
    chk("rstmid_no_start", n_start - nst, 0);
    chk("rstmid_no_frame", fa, 0);
    chk("rstmid_no_ldac", lo, 0);
    $display("reset mid-frame: starts after reset %0d", n_start - nst);
    ldac_run = 0;
    resp_auto = 1'b1;
    step();

    // Randomized frames checked against the reference frame builder.
    for (int r = 0; r < 40; r++) begin
      ea = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      wa = 12'($urandom);
      wb = 12'($urandom);
      exp = ref_frame(ea, eb, wa, wb);
      inj = (exp.size() > 0) ? $urandom_range(0, exp.size()) : 0;
      hold = (exp.size() > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_frame($sformatf("rnd%0d", r), ea, eb, wa, wb, exp,
                $urandom_range(1, 5), $urandom_range(0, 2), hold, inj,
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Shares the single SPI DAC link between the two waveform channels.
- On each 50 kHz sampling pulse, snapshots the channel A and B DAC words and sequences one 16-bit SPI write per enabled channel through the existing SPI master.
- Then pulses ldac_n so both DAC outputs update together.
- Sits between the waveform generators (sawtooth/other) and the SPI transmitter; flags frames that overrun the sample period.

Parameters:
- BUF_BIT, 1, value driven into word bit 14 (DAC VREF buffer control).
- GA_N_BIT, 1, value driven into word bit 13 (gain select, 1 = 1x).
- LDAC_CYCLES, 2, number of clk cycles ldac_n is held low; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- clk_sampling  in  1  one-clk-wide sampling strobe at 50 kHz.
- enableA  in  1  channel A participates in frames.
- enableB  in  1  channel B participates in frames.
- dacA_word  in  12  channel A DAC code.
- dacB_word  in  12  channel B DAC code.
- spi_tx_data  out  16  word presented to the SPI master.
- spi_tx_start  out  1  one-cycle start request to the SPI master.
- spi_busy  in  1  SPI master transfer in progress.
- spi_done  in  1  one-cycle pulse at end of transfer.
- ldac_n  out  1  DAC latch strobe, active-low.
- frame_active  out  1  high from strobe acceptance until the LDAC phase completes.
- overrun  out  1  sticky: a strobe arrived while a frame was active.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: spi_tx_data=0, spi_tx_start=0, ldac_n=1, frame_active=0, overrun=0; FSM in IDLE.
- Word format: [15] channel (0=A, 1=B), [14] BUF_BIT, [13] GA_N_BIT, [12] SHDN_N=1, [11:0] data.
- States: IDLE, START_A, WAIT_A, START_B, WAIT_B, LDAC.
- IDLE, clk_sampling=1:
  - Snapshot enableA, enableB, dacA_word and dacB_word into internal registers.
  - Snapshotted enables A=0 and B=0 -> stay IDLE; no frame, frame_active stays 0.
  - Otherwise frame_active=1 next cycle; go to START_A if A was enabled, else START_B.
  - Later changes to enable or word inputs do not affect the frame in progress.
- START_x:
  - Wait while spi_busy=1.
  - When spi_busy=0: spi_tx_start=1 for exactly one cycle, spi_tx_data loaded the same cycle, go to WAIT_x.
  - Minimum latency: strobe at edge T -> spi_tx_start high in cycle T+1.
- WAIT_x:
  - spi_tx_data held stable.
  - On spi_done: WAIT_A -> START_B if B is enabled in the snapshot, else LDAC; WAIT_B -> LDAC.
- LDAC:
  - ldac_n=0 for exactly LDAC_CYCLES cycles, then ldac_n=1, frame_active=0, go to IDLE.
  - The next strobe is accepted only from IDLE.
- clk_sampling in any state other than IDLE: pulse ignored (no re-snapshot), overrun set to 1.
- overrun:
  - Cleared by overrun_clr.
  - Set and clear in the same cycle: set wins.
- spi_done while in IDLE, START_x or LDAC: ignored.
- spi_busy still high when entering START_B: wait; no start is issued while busy.
- rst mid-frame:
  - Next cycle everything is at reset values, including ldac_n=1 and start=0.
  - The remainder of the frame is dropped; a later spi_done from the aborted transfer is ignored.
- No timeout: a missing spi_done holds WAIT_x indefinitely, and further strobes set overrun.

Optional Feature:
- Macro SAW_DAC_SHDN_EN.
- Defined:
  - A channel whose snapshotted enable is 0 still gets a slot in the frame.
  - Word sent is {ch, BUF_BIT, GA_N_BIT, 1'b0, 12'h000} (SHDN_N=0 powers down that DAC output).
  - Every strobe therefore produces a two-write frame, even with both enables 0.
- Not defined:
  - Disabled channels are skipped entirely as described above.
  - Both enables 0 -> no frame.

Test Plan:
- Basic frame: enableA=enableB=1, dacA_word=12'h800, dacB_word=12'h123, strobe.
  -> start at T+1 with spi_tx_data=16'h7800.
  -> after spi_done, second start with 16'hF123.
  -> after the second done, ldac_n low for exactly 2 cycles, then frame_active=0.
- B only: enableA=0, enableB=1, dacB_word=12'hFFF.
  -> single start with 16'hFFFF, then LDAC.
  -> with SAW_DAC_SHDN_EN: first word 16'h6000, then 16'hFFFF.
- Busy back-pressure: spi_busy held 1 for 10 cycles after the strobe.
  -> no spi_tx_start until the cycle spi_busy falls; exactly one start pulse.
- Overrun: second strobe while in WAIT_B.
  -> overrun=1, frame completes with the original snapshot words.
  -> overrun_clr pulse clears it; overrun_clr coincident with a new mid-frame strobe leaves overrun=1.
- Reset mid-frame: rst in WAIT_A, then spi_done 3 cycles later.
  -> all outputs at reset values, state stays IDLE, no further start or LDAC.
- Idle strobe: enableA=enableB=0, strobe (macro off).
  -> no spi_tx_start, ldac_n stays 1, frame_active stays 0, overrun stays 0.
